alu_sequencer: RTL and testbench

//  Board-level front end for the parametrised alu: debounces buttons, walks the user through A -> B -> OP entry with an FSM,

---
 rtl/alu_sequencer_pkg.sv | 31 +++
 rtl/alu_sequencer_btn_debounce.sv | 47 ++++
 rtl/alu_sequencer.sv | 165 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU board front end: FSM state encodings,
// supported opcodes and the opcode legality check.
package alu_sequencer_pkg;

  localparam int OP_W = 6;

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

  function automatic logic is_supported(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default:                                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_btn_debounce.sv
// One button: 2-FF synchronizer, stability counter and a single-cycle pulse
// on each accepted 0->1 level change.
module alu_sequencer_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      // Any sample matching the accepted level restarts the stability count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Board front end for the ALU: debounced buttons drive an A -> B -> OP entry
// FSM, the ALU result and flags are registered and shown on the LEDs.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int NB_BTN          = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic [NB_BTN-1:0]  i_btn,
  output logic [NB_DATA-1:0] o_led,
  output logic [2:0]         o_state,
  output logic               o_valid,
  output logic               o_err,
  output logic               o_zero,
  output logic               o_carry,
  output logic               o_ovf
);

  localparam int                 MSB         = NB_DATA - 1;
  localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

  logic [NB_BTN-1:0]  pulse;
  logic               cancel, confirm, toggle, op_ok;
  state_t             state, state_next;
  logic [NB_DATA-1:0] a, b, result, led_hold, led;
  logic [NB_OP-1:0]   op;
  logic               disp_mode;
  logic [NB_DATA:0]   sum_ext, diff_ext;
  logic [NB_DATA-1:0] alu_res;
  logic               alu_zero, alu_carry, alu_ovf;

  for (genvar i = 0; i < NB_BTN; i++) begin : g_btn
    alu_sequencer_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .btn     (i_btn[i]),
      .pulse   (pulse[i])
    );
  end

  // Same-cycle pulses: cancel wins, then confirm, then toggle.
  assign cancel  = pulse[1];
  assign confirm = pulse[0] & ~pulse[1];
  assign toggle  = pulse[2] & ~pulse[1] & ~pulse[0];
  assign op_ok   = is_supported(i_sw[NB_OP-1:0]);

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_LOAD_A;
    else         state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    if (cancel) begin
      state_next = S_LOAD_A;
    end else begin
      case (state)
        S_LOAD_A:  if (confirm)          state_next = S_LOAD_B;
        S_LOAD_B:  if (confirm)          state_next = S_LOAD_OP;
        S_LOAD_OP: if (confirm && op_ok) state_next = S_EXEC;
        S_EXEC:                          state_next = S_SHOW;
        S_SHOW:    if (confirm)          state_next = S_LOAD_A;
        default:                         state_next = S_LOAD_A;
      endcase
    end
  end

  // Flags come from a one-bit-wider add/sub so carry and borrow fall out directly.
  always_comb begin
    sum_ext   = {1'b0, a} + {1'b0, b};
    diff_ext  = {1'b0, a} - {1'b0, b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum_ext[MSB:0];
        alu_carry = sum_ext[NB_DATA];
        alu_ovf   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res   = diff_ext[MSB:0];
        alu_carry = diff_ext[NB_DATA];
        alu_ovf   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SRL:  alu_res = (b >= SHIFT_LIMIT) ? '0 : (a >> b);
      OP_SRA:  alu_res = (b >= SHIFT_LIMIT) ? {NB_DATA{a[MSB]}} : $unsigned($signed(a) >>> b);
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      a         <= '0;
      b         <= '0;
      op        <= '0;
      result    <= '0;
      o_zero    <= 1'b0;
      o_carry   <= 1'b0;
      o_ovf     <= 1'b0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      disp_mode <= 1'b0;
      led_hold  <= '0;
    end else begin
      led_hold <= led;
      if (cancel) begin
        o_valid <= 1'b0;
        o_err   <= 1'b0;
      end else begin
        case (state)
          S_LOAD_A: if (confirm) begin
            a       <= i_sw;
            o_valid <= 1'b0;
          end
          S_LOAD_B: if (confirm) b <= i_sw;
          S_LOAD_OP: if (confirm) begin
            if (op_ok) begin
              op    <= i_sw[NB_OP-1:0];
              o_err <= 1'b0;
            end else begin
              o_err <= 1'b1;
            end
          end
          S_EXEC: begin
            result    <= alu_res;
            o_zero    <= alu_zero;
            o_carry   <= alu_carry;
            o_ovf     <= alu_ovf;
            o_valid   <= 1'b1;
            disp_mode <= 1'b0;
          end
          S_SHOW: if (toggle) disp_mode <= ~disp_mode;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    led = led_hold;
    case (state)
      S_LOAD_A, S_LOAD_B: led = i_sw;
      S_LOAD_OP:          led = NB_DATA'(i_sw[NB_OP-1:0]);
      S_SHOW:             led = disp_mode ? NB_DATA'({o_ovf, o_carry, o_zero}) : result;
      default:            led = led_hold;
    endcase
  end

  assign o_led   = led;
  assign o_state = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a short debounce window; each task
// drives one scenario and compares outputs against hand-computed values.
module tb_alu_sequencer;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int NB_BTN  = 3;
  localparam int DEB     = 4;

  logic               i_clk = 1'b0;
  logic               i_reset = 1'b1;
  logic [NB_DATA-1:0] i_sw = '0;
  logic [NB_BTN-1:0]  i_btn = '0;
  logic [NB_DATA-1:0] o_led;
  logic [2:0]         o_state;
  logic               o_valid, o_err, o_zero, o_carry, o_ovf;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  alu_sequencer #(
    .NB_DATA         (NB_DATA),
    .NB_OP           (NB_OP),
    .NB_BTN          (NB_BTN),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sw    (i_sw),
    .i_btn   (i_btn),
    .o_led   (o_led),
    .o_state (o_state),
    .o_valid (o_valid),
    .o_err   (o_err),
    .o_zero  (o_zero),
    .o_carry (o_carry),
    .o_ovf   (o_ovf)
  );

  task automatic press(input logic [NB_BTN-1:0] mask, input int hold);
    @(negedge i_clk);
    i_btn = mask;
    repeat (hold) @(negedge i_clk);
    i_btn = '0;
    repeat (12) @(negedge i_clk);
  endtask

  task automatic enter(input logic [NB_DATA-1:0] val);
    i_sw = val;
    press(3'b001, 10);
  endtask

  task automatic test_reset;
    i_sw = 8'h5A;
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_state); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", o_err); end
    checks++; if ({o_ovf, o_carry, o_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {o_ovf, o_carry, o_zero}); end
    checks++; if (o_led !== 8'h5A) begin errors++; $display("FAIL reset_led: got %h expected 5a", o_led); end
  endtask

  task automatic test_add;
    enter(8'h7F);
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL add_state_b: got %0d expected 1", o_state); end
    i_sw = 8'h33; #1;
    checks++; if (o_led !== 8'h33) begin errors++; $display("FAIL add_echo_b: got %h expected 33", o_led); end
    enter(8'h01);
    checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL add_state_op: got %0d expected 2", o_state); end
    i_sw = 8'hE0; #1;
    checks++; if (o_led !== 8'h20) begin errors++; $display("FAIL add_echo_op: got %h expected 20", o_led); end
    // Clean press: pulse appears after edge DEB+3, EXEC one edge later, SHOW after that.
    i_sw = 8'h20;
    @(negedge i_clk);
    i_btn = 3'b001;
    repeat (DEB + 3) @(negedge i_clk);
    checks++; if (o_state !== 3'd2 || o_valid !== 1'b0) begin errors++; $display("FAIL add_latency_pre: got state %0d valid %b expected 2 0", o_state, o_valid); end
    @(negedge i_clk);
    checks++; if (o_state !== 3'd3 || o_valid !== 1'b0) begin errors++; $display("FAIL add_latency_exec: got state %0d valid %b expected 3 0", o_state, o_valid); end
    @(negedge i_clk);
    checks++; if (o_state !== 3'd4 || o_valid !== 1'b1) begin errors++; $display("FAIL add_latency_show: got state %0d valid %b expected 4 1", o_state, o_valid); end
    repeat (3) @(negedge i_clk);
    i_btn = '0;
    repeat (12) @(negedge i_clk);
    checks++; if (o_led !== 8'h80) begin errors++; $display("FAIL add_result: got %h expected 80", o_led); end
    checks++; if ({o_ovf, o_carry, o_zero} !== 3'b100) begin errors++; $display("FAIL add_flags: got %b expected 100", {o_ovf, o_carry, o_zero}); end
    checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL add_single_advance: got %0d expected 4", o_state); end
    enter(8'h05);
    checks++; if (o_state !== 3'd0 || o_valid !== 1'b1) begin errors++; $display("FAIL add_valid_held: got state %0d valid %b expected 0 1", o_state, o_valid); end
  endtask

  task automatic test_sub;
    enter(8'h05);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL sub_valid_clear: got %b expected 0", o_valid); end
    enter(8'h05);
    enter(8'h22);
    checks++; if (o_state !== 3'd4 || o_led !== 8'h00) begin errors++; $display("FAIL sub_equal: got state %0d led %h expected 4 00", o_state, o_led); end
    checks++; if ({o_ovf, o_carry, o_zero} !== 3'b001) begin errors++; $display("FAIL sub_equal_flags: got %b expected 001", {o_ovf, o_carry, o_zero}); end
    press(3'b100, 10);
    checks++; if (o_state !== 3'd4 || o_led !== 8'h01) begin errors++; $display("FAIL sub_toggle: got state %0d led %h expected 4 01", o_state, o_led); end
    enter(8'h00);
    enter(8'h03);
    enter(8'h05);
    enter(8'h22);
    checks++; if (o_led !== 8'hFE) begin errors++; $display("FAIL sub_borrow_led: got %h expected fe", o_led); end
    checks++; if ({o_ovf, o_carry, o_zero} !== 3'b010) begin errors++; $display("FAIL sub_borrow_flags: got %b expected 010", {o_ovf, o_carry, o_zero}); end
  endtask

  task automatic test_bad_opcode;
    enter(8'h00);
    enter(8'hF0);
    enter(8'h3C);
    enter(8'h3F);
    checks++; if (o_state !== 3'd2 || o_err !== 1'b1) begin errors++; $display("FAIL bad_op: got state %0d err %b expected 2 1", o_state, o_err); end
    checks++; if (o_led !== 8'h3F) begin errors++; $display("FAIL bad_op_echo: got %h expected 3f", o_led); end
    enter(8'h24);
    checks++; if (o_state !== 3'd4 || o_led !== 8'h30) begin errors++; $display("FAIL and_result: got state %0d led %h expected 4 30", o_state, o_led); end
    checks++; if (o_err !== 1'b0 || o_valid !== 1'b1) begin errors++; $display("FAIL and_status: got err %b valid %b expected 0 1", o_err, o_valid); end
    checks++; if ({o_ovf, o_carry, o_zero} !== 3'b000) begin errors++; $display("FAIL and_flags: got %b expected 000", {o_ovf, o_carry, o_zero}); end
  endtask

  task automatic test_cancel_sra;
    enter(8'h00);
    enter(8'h80);
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL cancel_setup: got %0d expected 1", o_state); end
    i_sw = 8'h55;
    press(3'b011, 10);
    checks++; if (o_state !== 3'd0 || o_valid !== 1'b0) begin errors++; $display("FAIL cancel_priority: got state %0d valid %b expected 0 0", o_state, o_valid); end
    enter(8'h80);
    enter(8'h09);
    enter(8'h03);
    checks++; if (o_state !== 3'd4 || o_led !== 8'hFF) begin errors++; $display("FAIL sra_fill: got state %0d led %h expected 4 ff", o_state, o_led); end
    checks++; if ({o_ovf, o_carry, o_zero} !== 3'b000) begin errors++; $display("FAIL sra_flags: got %b expected 000", {o_ovf, o_carry, o_zero}); end
  endtask

  task automatic test_reset_show;
    i_sw = 8'hA5;
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    checks++; if (o_state !== 3'd0 || o_valid !== 1'b0) begin errors++; $display("FAIL rst_show_state: got state %0d valid %b expected 0 0", o_state, o_valid); end
    checks++; if (o_led !== 8'hA5) begin errors++; $display("FAIL rst_show_led: got %h expected a5", o_led); end
    checks++; if ({o_ovf, o_carry, o_zero, o_err} !== 4'b0000) begin errors++; $display("FAIL rst_show_flags: got %b expected 0000", {o_ovf, o_carry, o_zero, o_err}); end
  endtask

  task automatic test_bounce;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      i_btn = 3'b001;
      repeat ((k % 3) + 1) @(negedge i_clk);
      i_btn = '0;
      repeat (3) @(negedge i_clk);
    end
    repeat (12) @(negedge i_clk);
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL bounce_ignored: got %0d expected 0", o_state); end
    i_sw = 8'h11;
    press(3'b001, 20);
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL hold_one_advance: got %0d expected 1", o_state); end
  endtask

  task automatic test_reset_load_op;
    enter(8'h22);
    checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL rst_op_setup: got %0d expected 2", o_state); end
    // Reset lands on the very edge that would consume the confirm pulse.
    i_sw = 8'h20;
    @(negedge i_clk);
    i_btn = 3'b001;
    repeat (DEB + 3) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    i_btn = '0;
    #1;
    checks++; if (o_state !== 3'd0 || o_valid !== 1'b0) begin errors++; $display("FAIL rst_op_state: got state %0d valid %b expected 0 0", o_state, o_valid); end
    checks++; if (o_led !== 8'h20) begin errors++; $display("FAIL rst_op_led: got %h expected 20", o_led); end
    repeat (12) @(negedge i_clk);
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL rst_op_no_stray: got %0d expected 0", o_state); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_bad_opcode();
    test_cancel_sra();
    test_reset_show();
    test_bounce();
    test_reset_load_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
